biquad8_coeff_sequencer: RTL and testbench

WISHBONE master that loads a complete coefficient set into the bank of `biquad8_wrapper` channels and then commits it. It walks an external coefficient table (synchronous RAM/ROM, 1-cycle read latency), issues one single-word write per coefficient to the FIR and pole-FIR registers of every enabled channel, and fires one `global_update_o` pulse so all channels switch coefficients together. It sits in the control clock domain, between the register/command logic and the WISHBONE interconnect feeding the filter bank.

---
 rtl/biquad8_coeff_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_biquad8_coeff_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_coeff_sequencer.sv
// rtl/biquad8_coeff_sequencer.sv - WISHBONE master that loads and commits a biquad8 coefficient set
//
// Walks a coefficient table (1-cycle read latency) and writes every word to the
// zero-FIR (0x04) and pole-FIR (0x10..0x1C) registers of each enabled channel,
// one classic single-cycle WISHBONE write per word, then fires global_update_o.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   start_i, chan_mask_i        start request and channel enable mask
//   abort_i                     abort request (honoured after the current write)
//   busy_o, done_o, err_o       status: in progress, end pulse, sticky error
//   global_update_o             one-cycle coefficient commit pulse
//   tbl_adr_o, tbl_rd_o, tbl_dat_i  coefficient table read port
//   wb_cyc_o .. wb_sel_o        WISHBONE master outputs
//   wb_ack_i, wb_err_i          WISHBONE slave responses
module biquad8_coeff_sequencer #(
    parameter int NCHAN   = 16,
    parameter int NZERO   = 8,
    parameter int NPOLE   = 8,
    parameter int TIMEOUT = 255,
    localparam int WPC  = NZERO + 4 * NPOLE,
    localparam int TADR = $clog2(NCHAN * WPC),
    localparam int CADR = $clog2(NCHAN)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              start_i,
    input  logic [NCHAN-1:0]  chan_mask_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              global_update_o,
    output logic [TADR-1:0]   tbl_adr_o,
    input  logic [17:0]       tbl_dat_i,
    output logic              tbl_rd_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [CADR+6:0]   wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam int WW = $clog2(WPC);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_UPDATE,
        S_FINISH
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [NCHAN-1:0] mask;
    logic [CADR-1:0]  chan;
    logic [WW-1:0]    word;
    logic [17:0]      coeff;
    logic [TW-1:0]    tcnt;
    logic             err_q;
    logic             abort_pend;
    logic             wrote;

    logic [CADR:0]    base;
    logic             found;
    logic [CADR-1:0]  nxt_chan;
    logic             last_word;
    logic             timeout_hit;
    logic             bus_fail;
    logic             abort_now;
    logic [6:0]       reg_off;

    // An abort seen in the same cycle as the closing ack still counts.
    assign abort_now   = abort_pend | abort_i;
    assign last_word   = (word == WW'(WPC - 1));
    assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
    assign bus_fail    = wb_err_i | (timeout_hit & ~wb_ack_i);

    // Channel search starts at the current channel on the first look after
    // start, and just past it once a channel has been fully written.
    always_comb begin
        base = {1'b0, chan};
        if (state == S_WRITE) begin
            base = {1'b0, chan} + (CADR + 1)'(1);
        end
    end

    // Lowest enabled channel at or above base; masked channels are passed over
    // in a single step so an enabled neighbour follows without dead cycles.
    always_comb begin
        found    = 1'b0;
        nxt_chan = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(base))) begin
                found    = 1'b1;
                nxt_chan = CADR'(i);
            end
        end
    end

    // Word-to-register mapping: zero-FIR words first, then four pole groups.
    always_comb begin
        reg_off = 7'h04;
        if (int'(word) >= NZERO) begin
            reg_off = 7'(16 + 4 * ((int'(word) - NZERO) / NPOLE));
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_SKIP;
                end
            end
            S_SKIP: begin
                if (abort_now) begin
                    state_n = S_FINISH;
                end else if (found) begin
                    state_n = S_FETCH;
                end else if (wrote) begin
                    state_n = S_UPDATE;
                end else begin
                    state_n = S_FINISH;
                end
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: state_n = S_WRITE;
            S_WRITE: begin
                if (bus_fail) begin
                    state_n = S_FINISH;
                end else if (wb_ack_i) begin
                    if (abort_now) begin
                        state_n = S_FINISH;
                    end else if (!last_word || found) begin
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_UPDATE;
                    end
                end
            end
            S_UPDATE: state_n = S_FINISH;
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mask       <= '0;
            chan       <= '0;
            word       <= '0;
            coeff      <= '0;
            tcnt       <= '0;
            err_q      <= 1'b0;
            abort_pend <= 1'b0;
            wrote      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mask  <= chan_mask_i;
                        err_q <= 1'b0;
                        chan  <= '0;
                        word  <= '0;
                        wrote <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (found) begin
                        chan <= nxt_chan;
                    end
                end
                S_LATCH: begin
                    coeff <= tbl_dat_i;
                    tcnt  <= '0;
                end
                S_WRITE: begin
                    tcnt <= tcnt + TW'(1);
                    if (bus_fail) begin
                        err_q <= 1'b1;
                    end else if (wb_ack_i) begin
                        wrote <= 1'b1;
                        if (last_word) begin
                            word <= '0;
                            if (found) begin
                                chan <= nxt_chan;
                            end
                        end else begin
                            word <= word + WW'(1);
                        end
                    end
                end
                default: ;
            endcase

            // Aborts only mean something while a sequence is running.
            if (state == S_IDLE) begin
                abort_pend <= 1'b0;
            end else if (abort_i) begin
                abort_pend <= 1'b1;
            end
        end
    end

    // Bus and table outputs decode straight from the state register so an
    // asynchronous reset drops cyc/stb without waiting for a clock edge.
    assign busy_o          = (state != S_IDLE);
    assign done_o          = (state == S_FINISH);
    assign global_update_o = (state == S_UPDATE);
    assign err_o           = err_q;

    assign tbl_rd_o  = (state == S_FETCH);
    assign tbl_adr_o = (state == S_FETCH) ? TADR'(int'(chan) * WPC + int'(word)) : '0;

    assign wb_cyc_o = (state == S_WRITE);
    assign wb_stb_o = (state == S_WRITE);
    assign wb_we_o  = (state == S_WRITE);
    assign wb_sel_o = (state == S_WRITE) ? 4'hF : 4'h0;
    assign wb_adr_o = (state == S_WRITE) ? {chan, reg_off} : '0;
    assign wb_dat_o = (state == S_WRITE) ? {14'b0, coeff} : '0;

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// tb/tb_biquad8_coeff_sequencer.sv - self-checking bench for biquad8_coeff_sequencer
module tb_biquad8_coeff_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] chan_mask_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        global_update_o;
    logic [9:0]  tbl_adr_o;
    logic [17:0] tbl_dat_i;
    logic        tbl_rd_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [10:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    biquad8_coeff_sequencer dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (rst_n),
        .start_i         (start_i),
        .chan_mask_i     (chan_mask_i),
        .abort_i         (abort_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .global_update_o (global_update_o),
        .tbl_adr_o       (tbl_adr_o),
        .tbl_dat_i       (tbl_dat_i),
        .tbl_rd_o        (tbl_rd_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_ack_i        (wb_ack_i),
        .wb_err_i        (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          dly;
        int          err_on;
        bit          nack;
        int          abort_on;
        int          exp_wr;
        int          exp_stb;
        int          exp_upd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // coefficient table with 1-cycle read latency
    logic [17:0] tbl_mem [0:1023];
    always @(posedge clk) begin
        if (tbl_rd_o) tbl_dat_i <= tbl_mem[tbl_adr_o];
    end

    // slave: ack after ack_delay wait cycles, optional err on the n-th write
    int ack_delay = 0;
    int err_on    = 0;
    bit never_ack = 1'b0;
    int wcnt;
    int wr_cnt;
    int wr_base = 0;
    logic hit;
    logic is_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt   <= 0;
            wr_cnt <= 0;
        end else begin
            wcnt <= wb_stb_o ? wcnt + 1 : 0;
            if (wb_stb_o && (wb_ack_i || wb_err_i)) wr_cnt <= wr_cnt + 1;
        end
    end

    assign hit      = wb_stb_o && !never_ack && (wcnt >= ack_delay);
    assign is_err   = hit && (err_on != 0) && (wr_cnt - wr_base + 1 == err_on);
    assign wb_ack_i = hit && !is_err;
    assign wb_err_i = is_err;

    // monitor
    int  cyc_n = 0;
    wr_t wr_q[$];
    int  n_upd, n_done, upd_cyc, done_cyc, stb_cycles, bus_bad;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (wb_stb_o) begin
            stb_cycles++;
            if (wb_sel_o !== 4'hF || wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) bus_bad++;
            if (wb_ack_i && !wb_err_i) wr_q.push_back('{wb_adr_o, wb_dat_o});
        end else if (wb_cyc_o) begin
            bus_bad++;
        end
        if (global_update_o) begin
            n_upd++;
            upd_cyc = cyc_n;
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc_n;
        end
    end

    // reference model: what the write stream should be for a mask
    wr_t exp_q[$];
    task automatic build_model(input logic [15:0] mask, input int limit);
        exp_q.delete();
        for (int ch = 0; ch < 16; ch++) begin
            if (mask[ch]) begin
                for (int w = 0; w < 40; w++) begin
                    int off;
                    off = (w < 8) ? 4 : 16 + 4 * ((w - 8) / 8);
                    if (exp_q.size() < limit)
                        exp_q.push_back('{11'(ch * 128 + off), {14'b0, tbl_mem[ch * 40 + w]}});
                end
            end
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        n_upd      = 0;
        n_done     = 0;
        upd_cyc    = -1;
        done_cyc   = -1;
        stb_cycles = 0;
        bus_bad    = 0;
    endtask

    // Runs one sequence; returns start-to-done latency (-1 if it never ended).
    task automatic run_seq(input string nm, input logic [15:0] mask, input int dly,
                           input int erron, input bit nack, input int abort_on,
                           output int lat);
        int  t0;
        bit  aborted;
        bit  fin;
        ack_delay = dly;
        err_on    = erron;
        never_ack = nack;
        wr_base   = wr_cnt;
        clear_mon();
        aborted = 1'b0;
        fin     = 1'b0;
        start_i     = 1'b1;
        chan_mask_i = mask;
        t0 = cyc_n;
        @(negedge clk);
        start_i     = 1'b0;
        chan_mask_i = $urandom;
        chk({nm, " busy_after_start"}, busy_o, 1);
        chk({nm, " err_cleared_on_start"}, err_o, 0);
        for (int k = 0; k < 8000 && !fin; k++) begin
            if (done_o) fin = 1'b1;
            if (abort_on > 0 && !aborted && wb_stb_o && (wr_cnt - wr_base == abort_on - 1)) begin
                abort_i = 1'b1;
                aborted = 1'b1;
            end else begin
                abort_i = 1'b0;
            end
            @(negedge clk);
        end
        abort_i = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s done_timeout: no done_o within bound", nm);
        end
        repeat (4) @(negedge clk);
        lat = (done_cyc >= 0) ? done_cyc - t0 : -1;
    endtask

    task automatic check_writes(input string nm);
        int n;
        chk({nm, " write_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s wr%0d_adr", nm, i), wr_q[i].adr, exp_q[i].adr);
            chk($sformatf("%s wr%0d_dat", nm, i), wr_q[i].dat, exp_q[i].dat);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        logic [15:0] m;
        int d;

        vecs[0] = '{"mask0001", 16'h0001, 0, 0, 1'b0, 0, 40, 40, 1, 1'b0, 123};
        vecs[1] = '{"mask8001", 16'h8001, 0, 0, 1'b0, 0, 80, 80, 1, 1'b0, 243};
        vecs[2] = '{"mask0000", 16'h0000, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 2};
        vecs[3] = '{"err5th", 16'h0001, 0, 5, 1'b0, 0, 4, 5, 0, 1'b1, 17};
        vecs[4] = '{"timeout", 16'h0001, 0, 0, 1'b1, 0, 0, 255, 0, 1'b1, 259};
        vecs[5] = '{"abort3rd", 16'h0001, 4, 0, 1'b0, 3, 3, 15, 0, 1'b0, 23};
        vecs[6] = '{"full", 16'hFFFF, 0, 0, 1'b0, 0, 640, 640, 1, 1'b0, 1923};

        for (int i = 0; i < 1024; i++) tbl_mem[i] = 18'(i);

        rst_n       = 1'b0;
        start_i     = 1'b0;
        chan_mask_i = '0;
        abort_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset err", err_o, 0);
        chk("reset update", global_update_o, 0);
        chk("reset cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o, tbl_rd_o}, 0);
        chk("reset adr_dat", {wb_adr_o, wb_dat_o, tbl_adr_o, wb_sel_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort while idle is ignored
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        @(negedge clk);
        chk("idle_abort busy", busy_o, 0);

        for (int v = 0; v < 7; v++) begin
            run_seq(vecs[v].name, vecs[v].mask, vecs[v].dly, vecs[v].err_on,
                    vecs[v].nack, vecs[v].abort_on, lat);
            build_model(vecs[v].mask, vecs[v].exp_wr);
            check_writes(vecs[v].name);
            chk({vecs[v].name, " stb_cycles"}, stb_cycles, vecs[v].exp_stb);
            chk({vecs[v].name, " updates"}, n_upd, vecs[v].exp_upd);
            chk({vecs[v].name, " dones"}, n_done, 1);
            chk({vecs[v].name, " err"}, err_o, vecs[v].exp_err);
            chk({vecs[v].name, " latency"}, lat, vecs[v].exp_lat);
            chk({vecs[v].name, " bus_protocol"}, bus_bad, 0);
            chk({vecs[v].name, " idle_after"}, busy_o, 0);
            if (vecs[v].exp_upd == 1)
                chk({vecs[v].name, " update_before_done"}, done_cyc - upd_cyc, 1);
            if (v == 1 && wr_q.size() > 40) begin
                chk("mask8001 ch15_first_adr", wr_q[40].adr, 11'h784);
                chk("mask8001 ch15_first_dat", wr_q[40].dat, 600);
            end
        end

        // async reset while stb is high
        ack_delay = 3;
        err_on    = 0;
        never_ack = 1'b0;
        clear_mon();
        start_i     = 1'b1;
        chan_mask_i = 16'h0001;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 20 && !wb_stb_o; k++) @(negedge clk);
        chk("rst_mid stb_seen", wb_stb_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid cyc_stb_drop", {wb_cyc_o, wb_stb_o}, 0);
        chk("rst_mid busy_drop", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid no_update", n_upd, 0);
        run_seq("after_rst", 16'h0001, 0, 0, 1'b0, 0, lat);
        build_model(16'h0001, 1 << 30);
        check_writes("after_rst");
        chk("after_rst updates", n_upd, 1);
        chk("after_rst latency", lat, 123);

        // randomized masks, table contents and ack delays against the model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 1024; i++) tbl_mem[i] = 18'($urandom);
            m = 16'($urandom) & 16'($urandom);
            if (r == 0) m = 16'h0400;
            d = $urandom_range(0, 3);
            run_seq($sformatf("rand%0d", r), m, d, 0, 1'b0, 0, lat);
            build_model(m, 1 << 30);
            check_writes($sformatf("rand%0d", r));
            chk($sformatf("rand%0d updates", r), n_upd, (exp_q.size() > 0) ? 1 : 0);
            chk($sformatf("rand%0d err", r), err_o, 0);
            chk($sformatf("rand%0d stb_cycles", r), stb_cycles, exp_q.size() * (d + 1));
            chk($sformatf("rand%0d latency", r), lat,
                1 + exp_q.size() * (3 + d) + ((exp_q.size() > 0) ? 2 : 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
